// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encoding, default widths
// and the round-robin search used by rr_arbiter.
package ram_arb_pkg;

    localparam int DEF_N_REQ  = 3;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RD_LAT = 1;

    localparam int MAX_REQ   = 8;
    localparam int IDX_MAX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [IDX_MAX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req searching from last+1 upward, wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [IDX_MAX_W-1:0] last,
                                         input int                   n);
        rr_pick_t             r;
        logic [IDX_MAX_W-1:0] jj;
        r = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            jj = IDX_MAX_W'((int'(last) + k) % n);
            if (k <= n && !r.found && req[jj]) begin
                r.found = 1'b1;
                r.idx   = jj;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signals of the RAM port arbiter. The arbiter uses
// the slave modport; requesters plus the RAM instance together form the master.
interface ram_port_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rdata;
    logic                    ram_en;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;

    modport master (
        output req, we, addr, wdata, lock, ram_rdata,
        input  gnt, ack, rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  req, we, addr, wdata, lock, ram_rdata,
        output gnt, ack, rdata, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_port_arbiter_rr.sv
// Round-robin picker: combinational search starting after the last served index;
// the pointer register only moves when upd_i is pulsed. Reset gives index 0 top priority.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    input  logic             upd_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    output logic             found_o,
    output logic [IDX_W-1:0] win_o
);
    logic [IDX_W-1:0] last_q, last_d;
    rr_pick_t         pick;

    always_comb begin
        pick   = rr_pick(MAX_REQ'(req_i), IDX_MAX_W'(last_q), N_REQ);
        last_d = upd_i ? upd_idx_i : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= IDX_W'(N_REQ - 1);
        else       last_q <= last_d;
    end

    assign found_o = pick.found;
    assign win_o   = IDX_W'(pick.idx);
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port sync RAM among N_REQ req/ack requesters, round-robin; optional bus lock under ARB_LOCK_EN.
// Latency: req seen in IDLE -> ack two cycles later (three for reads when RAM_RD_LAT=2); one access per 3-4 cycles.
// Backpressure: requesters hold req and operands until ack; requests arriving while busy wait for the next IDLE.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RAM_RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    ram_port_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] ACCESS = ST_ACCESS;
    localparam logic [1:0] WAIT   = ST_WAIT;
    localparam logic [1:0] ACK    = ST_ACK;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              rd_q, rd_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d, ack_q, ack_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d, sel_addr;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, sel_wdata;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              sel_we, rr_found, ptr_upd, lock_hit, lock_win_q;
    logic [IDX_W-1:0]  rr_win, win;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req_i     (bus.req),
        .upd_i     (ptr_upd),
        .upd_idx_i (win_q),
        .found_o   (rr_found),
        .win_o     (rr_win)
    );

`ifdef ARB_LOCK_EN
    logic             lock_vld_q, lock_vld_d, lock_win_d;
    logic [IDX_W-1:0] lock_own_q, lock_own_d;

    // A held lock overrides round-robin and leaves the pointer where it was.
    assign lock_hit = lock_vld_q && bus.req[lock_own_q] && bus.lock[lock_own_q];
    assign win      = lock_hit ? lock_own_q : rr_win;

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        lock_win_d = lock_win_q;
        if (state_q == IDLE) begin
            lock_vld_d = rr_found && bus.lock[win];
            lock_own_d = win;
            lock_win_d = lock_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
            lock_win_q <= 1'b0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            lock_win_q <= lock_win_d;
        end
    end
`else
    assign lock_hit   = 1'b0;
    assign lock_win_q = 1'b0;
    assign win        = rr_win;
`endif

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                sel_we    = bus.we[i];
                sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        rd_d        = rd_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    win_d       = win;
                    rd_d        = !sel_we;
                    gnt_d       = '0;
                    gnt_d[win]  = 1'b1;
                    ram_en_d    = 1'b1;
                    ram_we_d    = sel_we;
                    ram_addr_d  = sel_addr;
                    ram_wdata_d = sel_wdata;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (RAM_RD_LAT == 2 && rd_q) begin
                    state_d = WAIT;
                end else begin
                    ack_d[win_q] = 1'b1;
                    state_d      = ACK;
                end
            end
            WAIT: begin
                ack_d[win_q] = 1'b1;
                state_d      = ACK;
            end
            default: begin
                if (rd_q) rdata_d = bus.ram_rdata;
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign ptr_upd = (state_q == ACK) && !lock_win_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            win_q       <= '0;
            rd_q        <= 1'b0;
            gnt_q       <= '0;
            ack_q       <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            rd_q        <= rd_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Read data arrives from the RAM during the ack cycle, so it is passed straight through then.
    assign bus.rdata     = (state_q == ACK && rd_q) ? bus.ram_rdata : rdata_q;
    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, scoreboard of expected acks in grant order,
// per-scenario tasks with inline checks.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int N   = 3;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 1;

    typedef struct {
        int         idx;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    exp_t       sb[$];
    int         ack_t[$];
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] last_rd;
    logic [7:0] rd1, rd2;
    int         n_cmp = 0;
    int         n_err = 0;
    int         we_pulses = 0;
    int         ncyc = 0;
    int         ack_cnt [N];

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_RD_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 7 + 3);
    endfunction

    // Behavioural single-port RAM
    initial begin
        for (int a = 0; a < 256; a++) mem[a] = init_val(a);
        mem[8'h20] = 8'hA5;
        rd1 = '0;
        rd2 = '0;
        forever begin
            @(posedge clk);
            if (bus.ram_en) begin
                if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
                else            rd1 <= mem[bus.ram_addr];
            end
            rd2 <= rd1;
        end
    end
    assign bus.ram_rdata = (LAT == 2) ? rd2 : rd1;

    task automatic update_drive();
        for (int i = 0; i < N; i++) begin
            logic found;
            found = 1'b0;
            for (int k = 0; k < sb.size(); k++) begin
                if (!found && sb[k].idx == i) begin
                    found                  = 1'b1;
                    bus.we[i]              = sb[k].we;
                    bus.addr[i*AW +: AW]   = sb[k].addr;
                    bus.wdata[i*DW +: DW]  = sb[k].wdata;
                end
            end
            bus.req[i] = found;
        end
    endtask

    task automatic post(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.idx = i; e.we = we; e.addr = a; e.wdata = d;
        if (we) begin
            ref_mem[a] = d;
            e.rdata    = last_rd;
        end else begin
            e.rdata = ref_mem[a];
            last_rd = e.rdata;
        end
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard on each ack, checks the RAM port against the access in flight.
    initial begin
        exp_t       e;
        logic [N-1:0] oh;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!reset) begin
                n_cmp++;
                if ($countones(bus.gnt) > 1 || $countones(bus.ack) > 1 || (!bus.ram_en && bus.ram_we)) begin
                    n_err++;
                    $display("FAIL onehot: gnt=%b ack=%b ram_en=%b ram_we=%b", bus.gnt, bus.ack, bus.ram_en, bus.ram_we);
                end
                if (bus.ram_en) begin
                    if (bus.ram_we) we_pulses++;
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL ram_port: unexpected ram_en, addr=%h", bus.ram_addr);
                    end else if (bus.ram_we !== sb[0].we || bus.ram_addr !== sb[0].addr ||
                                 (sb[0].we && bus.ram_wdata !== sb[0].wdata)) begin
                        n_err++;
                        $display("FAIL ram_port: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                                 bus.ram_we, bus.ram_addr, bus.ram_wdata, sb[0].we, sb[0].addr, sb[0].wdata);
                    end
                end
                if (bus.ack !== '0) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL ack: unexpected ack=%b", bus.ack);
                    end else begin
                        e  = sb.pop_front();
                        oh = N'(1) << e.idx;
                        if (bus.ack !== oh || bus.gnt !== oh) begin
                            n_err++;
                            $display("FAIL ack_order: ack=%b gnt=%b, want %b", bus.ack, bus.gnt, oh);
                        end
                        n_cmp++;
                        if (bus.rdata !== e.rdata) begin
                            n_err++;
                            $display("FAIL rdata: got %h, want %h (req %0d addr %h)", bus.rdata, e.rdata, e.idx, e.addr);
                        end
                        ack_cnt[e.idx]++;
                        ack_t.push_back(ncyc);
                        update_drive();
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d accesses still pending, want 0", sb.size());
            sb.delete();
            update_drive();
        end
        @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.gnt, bus.ack, bus.ram_en, bus.ram_we} !== '0) begin
            n_err++;
            $display("FAIL reset_ctl: gnt=%b ack=%b en=%b we=%b, want all 0", bus.gnt, bus.ack, bus.ram_en, bus.ram_we);
        end
        n_cmp++;
        if ({bus.rdata, bus.ram_addr, bus.ram_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, want 0", bus.rdata, bus.ram_addr, bus.ram_wdata);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_single_read();
        post(1, 1'b0, 8'h20, 8'h00);
        update_drive();
        @(negedge clk); #1;
        n_cmp++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== 8'h20 || bus.gnt !== 3'b010) begin
            n_err++;
            $display("FAIL single_access: en=%b addr=%h gnt=%b, want 1/20/010", bus.ram_en, bus.ram_addr, bus.gnt);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.ack !== 3'b010 || bus.rdata !== 8'hA5) begin
            n_err++;
            $display("FAIL single_ack: ack=%b rdata=%h, want 010/a5", bus.ack, bus.rdata);
        end
        wait_drain();
    endtask

    task automatic test_write_read();
        int w0 = we_pulses;
        post(0, 1'b1, 8'h10, 8'h3C);
        post(0, 1'b0, 8'h10, 8'h00);
        update_drive();
        wait_drain();
        n_cmp++;
        if (we_pulses - w0 != 1) begin
            n_err++;
            $display("FAIL write_pulses: got %0d ram_we cycles, want 1", we_pulses - w0);
        end
    endtask

    task automatic test_reset_mid_access();
        post(0, 1'b0, 8'h33, 8'h00);
        update_drive();
        wait_drain();
        post(1, 1'b0, 8'h44, 8'h00);
        update_drive();
        @(negedge clk); #1;
        n_cmp++;
        if (bus.ram_en !== 1'b1 || bus.gnt !== 3'b010) begin
            n_err++;
            $display("FAIL abort_setup: en=%b gnt=%b, want 1/010", bus.ram_en, bus.gnt);
        end
        #1 reset = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if ({bus.gnt, bus.ack, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rdata} !== '0) begin
            n_err++;
            $display("FAIL abort_clear: gnt=%b ack=%b en=%b addr=%h rdata=%h, want all 0",
                     bus.gnt, bus.ack, bus.ram_en, bus.ram_addr, bus.rdata);
        end
        sb.delete();
        update_drive();
        last_rd = 8'h00;
        @(negedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < N; i++) post(i, 1'b0, 8'(8'h50 + i), 8'h00);
        update_drive();
        wait_drain();
    endtask

    task automatic test_contention();
        ack_t.delete();
        post(0, 1'b0, 8'h60, 8'h00);
        post(1, 1'b1, 8'h61, 8'hC3);
        post(2, 1'b0, 8'h62, 8'h00);
        post(0, 1'b0, 8'h63, 8'h00);
        post(1, 1'b0, 8'h61, 8'h00);
        post(2, 1'b0, 8'h65, 8'h00);
        update_drive();
        wait_drain();
        n_cmp++;
        if (ack_t.size() != 6 || ack_t[ack_t.size()-1] - ack_t[0] != 15) begin
            n_err++;
            $display("FAIL throughput: %0d acks spanning %0d cycles, want 6 spanning 15",
                     ack_t.size(), (ack_t.size() > 0) ? ack_t[ack_t.size()-1] - ack_t[0] : -1);
        end
    endtask

    task automatic test_late_arrival();
        post(0, 1'b0, 8'h70, 8'h00);
        update_drive();
        @(negedge clk); #2;
        n_cmp++;
        if (bus.gnt !== 3'b001 || bus.ram_en !== 1'b1) begin
            n_err++;
            $display("FAIL late_setup: gnt=%b en=%b, want 001/1", bus.gnt, bus.ram_en);
        end
        post(2, 1'b0, 8'h72, 8'h00);
        update_drive();
        wait_drain();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        int base = ack_cnt[0];
        int cyc  = 0;
        bus.lock = 3'b001;
        post(0, 1'b0, 8'h80, 8'h00);
        post(0, 1'b0, 8'h81, 8'h00);
        post(0, 1'b0, 8'h82, 8'h00);
        post(1, 1'b0, 8'h90, 8'h00);
        post(0, 1'b0, 8'h83, 8'h00);
        update_drive();
        while (ack_cnt[0] < base + 3 && cyc < 100) begin
            @(negedge clk); #2;
            cyc++;
        end
        n_cmp++;
        if (ack_cnt[0] < base + 3) begin
            n_err++;
            $display("FAIL lock_wait: requester 0 got %0d acks, want 3", ack_cnt[0] - base);
        end
        bus.lock = 3'b000;
        wait_drain();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.lock  = '0;
        last_rd   = 8'h00;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        ref_mem[8'h20] = 8'hA5;
        test_reset();
        test_single_read();
        test_write_read();
        test_reset_mid_access();
        test_contention();
        test_late_arrival();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
